// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard / control-flow controller.
package pipe_ctrl_pkg;

  localparam int DRAIN_CYCLES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_INV     = 2'd2,
    ST_REFETCH = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds an ID source.
module hazard_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_ren,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = id_valid && ex_valid && ex_mem_ren && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stalls/flushes for memory wait, redirects, traps,
// load-use hazards, and the fence.i drain / I-cache invalidate / refetch sequence.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [31:0] id_pc,
  input  logic        id_fence_i,
  input  logic        id_ecall,
  input  logic        id_mret,
  input  logic        ex_valid,
  input  logic        ex_mem_ren,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mem_busy,
  input  logic        icache_inv_ack,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        icache_inv_req,
  output logic [31:0] stall_count
);

  localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        icache_inv_req_q, icache_inv_req_d;
  logic        load_use;

  hazard_detect u_hazard_detect (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_valid   (ex_valid),
    .ex_mem_ren (ex_mem_ren),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    state_d        = state_q;
    cnt_d          = cnt_q;

    if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_valid && ex_redirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_target;
            flush_id       = 1'b1;
            flush_ex       = 1'b1;
          end else if (id_valid && id_ecall) begin
            redirect_valid = 1'b1;
            redirect_pc    = mtvec;
            flush_id       = 1'b1;
          end else if (id_valid && id_mret) begin
            redirect_valid = 1'b1;
            redirect_pc    = mepc;
            flush_id       = 1'b1;
          end else if (id_valid && id_fence_i) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            cnt_d    = DRAIN_LOAD;
            state_d  = ST_DRAIN;
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        ST_DRAIN: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          if (cnt_q == 32'd0) state_d = ST_INV;
          else                cnt_d   = cnt_q - 32'd1;
        end
        ST_INV: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          if (icache_inv_ack) state_d = ST_REFETCH;
        end
        ST_REFETCH: begin
          // ID still holds the fence.i, so refetch resumes at the instruction after it.
          redirect_valid = 1'b1;
          redirect_pc    = id_pc + 32'd4;
          flush_id       = 1'b1;
          state_d        = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    if (reset) begin
      stall_if       = 1'b0;
      stall_id       = 1'b0;
      stall_ex       = 1'b0;
      flush_id       = 1'b0;
      flush_ex       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
    end

    icache_inv_req_d = (state_d == ST_INV);
    stall_count_d    = stall_count_q + {31'd0, stall_id};
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_RUN;
      cnt_q            <= 32'd0;
      stall_count_q    <= 32'd0;
      icache_inv_req_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      stall_count_q    <= stall_count_d;
      icache_inv_req_q <= icache_inv_req_d;
    end
  end

  assign icache_inv_req = icache_inv_req_q;
  assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, redirect priority, fence.i sequence, reset.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic [31:0] id_pc;
  logic        id_fence_i, id_ecall, id_mret;
  logic        ex_valid, ex_mem_ren;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic [31:0] ex_target, mtvec, mepc;
  logic        mem_busy, icache_inv_ack;
  logic        stall_if, stall_id, stall_ex, flush_id, flush_ex;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_inv_req;
  logic [31:0] stall_count;

  int npass = 0;
  int ntotal = 0;

  always #5 clock = ~clock;

  pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_pc(id_pc),
    .id_fence_i(id_fence_i), .id_ecall(id_ecall), .id_mret(id_mret),
    .ex_valid(ex_valid), .ex_mem_ren(ex_mem_ren), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mtvec(mtvec), .mepc(mepc),
    .mem_busy(mem_busy), .icache_inv_ack(icache_inv_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_inv_req(icache_inv_req), .stall_count(stall_count)
  );

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_pc = 32'h0;
    id_fence_i = 0; id_ecall = 0; id_mret = 0;
    ex_valid = 0; ex_mem_ren = 0; ex_rd = 0; ex_redirect = 0; ex_target = 0;
    mtvec = 32'h7000_0000; mepc = 32'h6000_0010;
    mem_busy = 0; icache_inv_ack = 0;
  endtask

  // Packs the combinational control outputs as {stall_if,stall_id,stall_ex,flush_id,flush_ex,redirect_valid}.
  function automatic logic [5:0] ctl();
    return {stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect_valid};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ex_valid = 1; ex_redirect = 1; ex_target = 32'h1234_5678;
    id_valid = 1; id_fence_i = 1;
    mem_busy = 1;
    @(negedge clock); #1;
    ntotal++;
    if (ctl() !== 6'b0) $display("FAIL reset_ctl got %b exp %b", ctl(), 6'b0); else npass++;
    ntotal++;
    if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc got %h exp %h", redirect_pc, 32'h0); else npass++;
    @(negedge clock); #1;
    ntotal++;
    if (stall_count !== 32'd0) $display("FAIL reset_stall_count got %0d exp 0", stall_count); else npass++;
    ntotal++;
    if (icache_inv_req !== 1'b0) $display("FAIL reset_inv_req got %b exp 0", icache_inv_req); else npass++;
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clock);
    idle_inputs();
    ex_valid = 1; ex_mem_ren = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #1;
    ntotal++;
    if (ctl() !== 6'b110010) $display("FAIL lu_ctl got %b exp %b", ctl(), 6'b110010); else npass++;
    @(negedge clock);
    ex_valid = 0; ex_mem_ren = 0; ex_rd = 0;
    #1;
    ntotal++;
    if (ctl() !== 6'b000000) $display("FAIL lu_clear_ctl got %b exp %b", ctl(), 6'b000000); else npass++;
    ntotal++;
    if (stall_count !== 32'd1) $display("FAIL lu_stall_count got %0d exp 1", stall_count); else npass++;
    // rd=0 load with rs1=0: no hazard
    @(negedge clock);
    idle_inputs();
    ex_valid = 1; ex_mem_ren = 1; ex_rd = 5'd0;
    id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd7;
    #1;
    ntotal++;
    if (ctl() !== 6'b000000) $display("FAIL lu_rd0_ctl got %b exp %b", ctl(), 6'b000000); else npass++;
    // load to rs1 but ID not valid: no hazard
    @(negedge clock);
    ex_rd = 5'd9; id_rs1 = 5'd9; id_valid = 0;
    #1;
    ntotal++;
    if (stall_id !== 1'b0) $display("FAIL lu_id_invalid got %b exp 0", stall_id); else npass++;
  endtask

  task automatic test_redirect_priority();
    @(negedge clock);
    idle_inputs();
    ex_valid = 1; ex_redirect = 1; ex_target = 32'h8000_0100;
    id_valid = 1; id_ecall = 1;
    #1;
    ntotal++;
    if (ctl() !== 6'b000111) $display("FAIL exred_ctl got %b exp %b", ctl(), 6'b000111); else npass++;
    ntotal++;
    if (redirect_pc !== 32'h8000_0100) $display("FAIL exred_pc got %h exp %h", redirect_pc, 32'h8000_0100); else npass++;
    @(negedge clock);
    ex_valid = 0; ex_redirect = 0;
    #1;
    ntotal++;
    if (ctl() !== 6'b000101) $display("FAIL ecall_ctl got %b exp %b", ctl(), 6'b000101); else npass++;
    ntotal++;
    if (redirect_pc !== 32'h7000_0000) $display("FAIL ecall_pc got %h exp %h", redirect_pc, 32'h7000_0000); else npass++;
    @(negedge clock);
    id_ecall = 0; id_mret = 1;
    #1;
    ntotal++;
    if (redirect_pc !== 32'h6000_0010) $display("FAIL mret_pc got %h exp %h", redirect_pc, 32'h6000_0010); else npass++;
    // mem_busy outranks the redirect
    @(negedge clock);
    mem_busy = 1;
    #1;
    ntotal++;
    if (ctl() !== 6'b111000) $display("FAIL busy_ctl got %b exp %b", ctl(), 6'b111000); else npass++;
    ntotal++;
    if (redirect_pc !== 32'h0) $display("FAIL busy_pc got %h exp 0", redirect_pc); else npass++;
    @(negedge clock);
    idle_inputs();
  endtask

  // Runs one fence.i sequence; busy_at lists loop iterations (0 = first DRAIN cycle) with mem_busy=1.
  task automatic run_fence(input int busy_a, input int busy_b, input int ack_inv_cycle,
                           output int drain_cycles, output int inv_cycles,
                           output logic [31:0] sc_delta, output logic [31:0] refetch_pc,
                           output logic refetch_flush, output logic done);
    logic [31:0] sc0;
    drain_cycles = 0; inv_cycles = 0; done = 0;
    sc_delta = 0; refetch_pc = 0; refetch_flush = 0;
    @(negedge clock);
    idle_inputs();
    id_valid = 1; id_fence_i = 1; id_pc = 32'h8000_0040;
    #1;
    ntotal++;
    if (ctl() !== 6'b110010) $display("FAIL fence_entry_ctl got %b exp %b", ctl(), 6'b110010); else npass++;
    @(negedge clock);
    id_fence_i = 0;
    sc0 = stall_count;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge clock);
      mem_busy = (i == busy_a || i == busy_b);
      // spurious redirect and ack while draining must be ignored
      ex_valid = (i == 0); ex_redirect = (i == 0); ex_target = 32'hDEAD_0000;
      if (icache_inv_req) begin
        inv_cycles++;
        icache_inv_ack = (inv_cycles == ack_inv_cycle);
      end else begin
        icache_inv_ack = (i == 0);
      end
      #1;
      if (redirect_valid) begin
        done = 1;
        refetch_pc = redirect_pc;
        refetch_flush = flush_id;
        sc_delta = stall_count - sc0;
      end else if (stall_id && !icache_inv_req) begin
        drain_cycles++;
        if (mem_busy) begin
          ntotal++;
          if ({stall_ex, flush_ex} !== 2'b10)
            $display("FAIL busy_drain got stall_ex/flush_ex=%b exp 10", {stall_ex, flush_ex});
          else npass++;
        end
      end
    end
    if (!done) begin
      ntotal++;
      $display("FAIL fence_timeout got no refetch exp refetch within 40 cycles");
    end
    @(negedge clock);
    idle_inputs();
    #1;
    ntotal++;
    if (ctl() !== 6'b000000) $display("FAIL fence_back_to_run got %b exp %b", ctl(), 6'b000000); else npass++;
  endtask

  task automatic test_fence_i();
    int d, v; logic [31:0] sc, pc; logic fl, ok;
    run_fence(-1, -1, 3, d, v, sc, pc, fl, ok);
    if (ok) begin
      ntotal++;
      if (d !== 3) $display("FAIL fence_drain_cycles got %0d exp 3", d); else npass++;
      ntotal++;
      if (v !== 3) $display("FAIL fence_inv_cycles got %0d exp 3", v); else npass++;
      ntotal++;
      if (pc !== 32'h8000_0044) $display("FAIL fence_refetch_pc got %h exp %h", pc, 32'h8000_0044); else npass++;
      ntotal++;
      if (fl !== 1'b1) $display("FAIL fence_refetch_flush got %b exp 1", fl); else npass++;
      ntotal++;
      if (sc !== 32'd6) $display("FAIL fence_stall_count got %0d exp 6", sc); else npass++;
    end
  endtask

  task automatic test_busy_in_drain();
    int d, v; logic [31:0] sc, pc; logic fl, ok;
    run_fence(1, 2, 1, d, v, sc, pc, fl, ok);
    if (ok) begin
      ntotal++;
      if (d !== 5) $display("FAIL busy_drain_cycles got %0d exp 5", d); else npass++;
      ntotal++;
      if (v !== 1) $display("FAIL busy_inv_cycles got %0d exp 1", v); else npass++;
    end
  endtask

  task automatic test_reset_in_inv();
    bit reached = 0;
    @(negedge clock);
    idle_inputs();
    id_valid = 1; id_fence_i = 1; id_pc = 32'h8000_0040;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clock);
      id_fence_i = 0;
      #1;
      reached = icache_inv_req;
    end
    ntotal++;
    if (!reached) $display("FAIL rst_inv_reach got inv_req=0 exp 1");
    else npass++;
    reset = 1;
    #1;
    ntotal++;
    if (ctl() !== 6'b000000) $display("FAIL rst_inv_ctl got %b exp %b", ctl(), 6'b000000); else npass++;
    @(negedge clock);
    reset = 0;
    icache_inv_ack = 1;
    #1;
    ntotal++;
    if (icache_inv_req !== 1'b0) $display("FAIL rst_inv_req got %b exp 0", icache_inv_req); else npass++;
    ntotal++;
    if (stall_count !== 32'd0) $display("FAIL rst_inv_stall_count got %0d exp 0", stall_count); else npass++;
    ntotal++;
    if (ctl() !== 6'b000000) $display("FAIL rst_inv_run_ctl got %b exp %b", ctl(), 6'b000000); else npass++;
    @(negedge clock);
    icache_inv_ack = 0;
    #1;
    ntotal++;
    if (redirect_valid !== 1'b0) $display("FAIL rst_inv_ack_ignored got %b exp 0", redirect_valid); else npass++;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_fence_i();
    test_busy_in_drain();
    test_reset_in_inv();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, cycles for EX/MEM/WB to empty before I-cache invalidate.
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  5  ID source registers
- id_pc  in  32  ID instruction PC
- id_fence_i, id_ecall, id_mret  in  1  ID decode flags
- ex_valid  in  1  EX holds a valid instruction
- ex_mem_ren  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  EX branch taken or jump
- ex_target  in  32  EX redirect target
- mtvec, mepc  in  32  CSR values
- mem_busy  in  1  data memory not ready
- icache_inv_ack  in  1  invalidate complete
- stall_if, stall_id, stall_ex  out  1  hold stage register
- flush_id, flush_ex  out  1  load NOP / valid=0 into stage register
- redirect_valid  out  1  fetch PC override this cycle
- redirect_pc  out  32  fetch PC override value
- icache_inv_req  out  1  request I-cache invalidate
- stall_count  out  32  cycles with stall_id=1

Function
REQ-003 SHALL implement FSM states RUN, DRAIN, INV, REFETCH.
REQ-004 In RUN, SHALL evaluate events combinationally, priority high to low: mem_busy, ex_redirect, ecall/mret, fence.i, load-use.
REQ-005 mem_busy=1 (any state): stall_if=stall_id=stall_ex=1, no flush, no redirect, FSM/counter frozen.
REQ-006 ex_valid&&ex_redirect: redirect_valid=1, redirect_pc=ex_target, flush_id=1, flush_ex=1; ID flags ignored that cycle.
REQ-007 id_valid&&id_ecall: redirect_pc=mtvec; id_valid&&id_mret: redirect_pc=mepc; both with redirect_valid=1, flush_id=1.
REQ-008 id_valid&&id_fence_i: stall_if=stall_id=1, flush_ex=1, counter loaded with DRAIN_CYCLES-1, next state DRAIN.
REQ-009 Load-use when ex_valid&&ex_mem_ren&&ex_rd!=0&&(ex_rd==id_rs1||ex_rd==id_rs2)&&id_valid: stall_if=stall_id=1, flush_ex=1 for exactly that cycle; no state change.
REQ-010 DRAIN: stall_if=stall_id=1, flush_ex=1; counter decrements each cycle; at counter 0 next state INV.
REQ-011 INV: icache_inv_req=1 and stall_if=stall_id=1, flush_ex=1 until icache_inv_ack=1; that cycle next state REFETCH.
REQ-012 REFETCH (one cycle): redirect_valid=1, redirect_pc=id_pc+4 (mod 2^32), flush_id=1, next state RUN.
REQ-013 icache_inv_req SHALL be registered (state-decoded), no glitch; ack outside INV ignored.
REQ-014 ex_redirect outside RUN SHALL be ignored (EX holds bubbles there).
REQ-015 stall_count SHALL increment by 1 in every cycle with stall_id=1, wrapping 0xFFFFFFFF to 0.
REQ-016 All outputs not asserted by REQ-005..012 SHALL be 0; redirect_pc SHALL be 0 when redirect_valid=0.

Reset
REQ-017 On reset=1 at a clock edge: state=RUN, counter=0, stall_count=0, icache_inv_req=0, regardless of current state (including mid-DRAIN/INV).
REQ-018 While reset=1, all combinational outputs SHALL be 0.

Structure
REQ-019 State enum and DRAIN_CYCLES default SHALL live in the shared package pipe_ctrl_pkg.
REQ-020 Load-use comparison SHALL be a sub-module hazard_detect (pure combinational); FSM, counters and priority mux stay in pipe_ctrl.

Verification
REQ-021 Load-use: ex lw rd=5, id rs2=5 -> one cycle stall_id=1, flush_ex=1; next cycle clear; stall_count=1.
REQ-022 rd=0 load, id rs1=0 -> no stall.
REQ-023 ex_redirect=1 ex_target=0x80000100 with id_ecall=1 -> redirect_pc=0x80000100, flush_id=flush_ex=1, mtvec ignored.
REQ-024 fence.i at id_pc=0x80000040, DRAIN_CYCLES=3, ack 2 cycles after INV entry -> 3 DRAIN, 3 INV cycles, then REFETCH redirect_pc=0x80000044; stall_count=6.
REQ-025 mem_busy=1 for 2 cycles mid-DRAIN -> counter frozen, DRAIN lasts 5 cycles total.
REQ-026 reset asserted during INV -> next cycle RUN, icache_inv_req=0, stall_count=0.
